// File: rtl/cbus_axi_bridge_pkg.sv
// ============================================================================
// Module   : cbus_axi_bridge_pkg
// Purpose  : Shared types and constants for the CBus-to-AXI3 bridge:
//            CBus request/response structs, AXI burst/size encodings,
//            AXI3 burst-length bound and the bridge state enum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_axi_bridge_pkg;

  // AXI3 caps INCR bursts at 16 beats.
  localparam int AXI3_MAX_BURST = 16;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;       // beats - 1
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [2:0] {
    AXI_SIZE_1B = 3'd0,
    AXI_SIZE_2B = 3'd1,
    AXI_SIZE_4B = 3'd2
  } axi_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } bridge_state_e;

  // Illegal over-long requests are truncated to the largest legal burst.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) > max_len - 1) return 4'(max_len - 1);
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cbus_arbiter.sv
// ============================================================================
// Module   : cbus_arbiter
// Purpose  : Picks one requesting CBus port and remembers the grant.
//            Default: fixed priority, lowest index wins.
//            Macro CBUS_ROUND_ROBIN_EN: round-robin, search starts at the
//            last granted index + 1 (mod NUM_PORTS).
// Ports    : aclk, aresetn     - clock, async active-low reset
//            i_req             - per-port request valid
//            i_en              - arbitration allowed this cycle (bridge idle)
//            o_win_valid       - some port requests this cycle
//            o_win_idx         - this cycle's winner (combinational)
//            o_gnt_idx         - registered grant, held until next arbitration
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_en,
  output logic                 o_win_valid,
  output logic [IDX_W-1:0]     o_win_idx,
  output logic [IDX_W-1:0]     o_gnt_idx
);

  logic [IDX_W-1:0] r_gnt;

`ifdef CBUS_ROUND_ROBIN_EN
  // Lowest requester above the previous grant wins; if none, wrap to the
  // lowest requester overall.
  logic             w_above;
  logic [IDX_W-1:0] w_above_idx;

  always_comb begin
    o_win_valid = 1'b0;
    o_win_idx   = '0;
    w_above     = 1'b0;
    w_above_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_win_valid = 1'b1;
        o_win_idx   = IDX_W'(i);
        if (i > int'(r_gnt)) begin
          w_above     = 1'b1;
          w_above_idx = IDX_W'(i);
        end
      end
    end
    if (w_above) o_win_idx = w_above_idx;
  end
`else
  // Descending scan: the last hit is the lowest index.
  always_comb begin
    o_win_valid = 1'b0;
    o_win_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_win_valid = 1'b1;
        o_win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_gnt <= '0;
    end else if (i_en && o_win_valid) begin
      r_gnt <= o_win_idx;
    end
  end

  assign o_gnt_idx = r_gnt;

endmodule

`default_nettype wire

// File: rtl/cbus_axi_bridge.sv
// ============================================================================
// Module   : cbus_axi_bridge
// Purpose  : Arbitrates NUM_PORTS CBus masters onto one AXI3 master port,
//            one transaction in flight, INCR bursts up to MAX_LEN beats.
//            Arbitration mode selected by macro CBUS_ROUND_ROBIN_EN
//            (defined: round-robin; undefined: fixed priority, port 0 first).
// Ports    : aclk, aresetn      - clock, async active-low reset
//            i_creq / o_cresp   - per-port CBus request / response
//            o_ar* / i_arready  - AXI3 read address channel
//            i_r*  / o_rready   - AXI3 read data channel
//            o_aw* / i_awready  - AXI3 write address channel
//            o_w*  / i_wready   - AXI3 write data channel
//            i_b*  / o_bready   - AXI3 write response channel
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_LEN   = 16,
  parameter int ID_W      = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  cbus_req_t  [NUM_PORTS-1:0]  i_creq,
  output cbus_resp_t [NUM_PORTS-1:0]  o_cresp,
  // read address
  output logic [ID_W-1:0]             o_arid,
  output logic [31:0]                 o_araddr,
  output logic [3:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  output logic [1:0]                  o_arlock,
  output logic [3:0]                  o_arcache,
  output logic [2:0]                  o_arprot,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  // read data
  input  logic [ID_W-1:0]             i_rid,
  input  logic [31:0]                 i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rlast,
  input  logic                        i_rvalid,
  output logic                        o_rready,
  // write address
  output logic [ID_W-1:0]             o_awid,
  output logic [31:0]                 o_awaddr,
  output logic [3:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic [1:0]                  o_awlock,
  output logic [3:0]                  o_awcache,
  output logic [2:0]                  o_awprot,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  // write data
  output logic [ID_W-1:0]             o_wid,
  output logic [31:0]                 o_wdata,
  output logic [3:0]                  o_wstrb,
  output logic                        o_wlast,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  // write response
  input  logic [ID_W-1:0]             i_bid,
  input  logic [1:0]                  i_bresp,
  input  logic                        i_bvalid,
  output logic                        o_bready
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  bridge_state_e          r_state;
  bridge_state_e          w_state_nxt;
  logic [31:0]            r_addr;
  logic [2:0]             r_size;
  logic [3:0]             r_len;
  logic [3:0]             r_beat;

  logic [NUM_PORTS-1:0]   w_req;
  logic                   w_arb_en;
  logic                   w_win_valid;
  logic [IDX_W-1:0]       w_win_idx;
  logic [IDX_W-1:0]       w_gnt;
  logic                   w_wlast;
  logic                   w_whs;

  // Response/ID fields are not inspected by this bridge.
  logic w_unused;
  assign w_unused = ^{i_rid, i_rresp, i_bid, i_bresp};

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_req[i] = i_creq[i].valid;
  end

  cbus_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arbiter (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_req       (w_req),
    .i_en        (w_arb_en),
    .o_win_valid (w_win_valid),
    .o_win_idx   (w_win_idx),
    .o_gnt_idx   (w_gnt)
  );

  // Address channels: valids decode the registered state, so they rise the
  // cycle after the grant and stay up until the handshake.
  assign o_arvalid = (r_state == ST_AR);
  assign o_arid    = ID_W'(w_gnt);
  assign o_araddr  = r_addr;
  assign o_arlen   = r_len;
  assign o_arsize  = r_size;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0000;
  assign o_arprot  = 3'b000;

  assign o_awvalid = (r_state == ST_AW);
  assign o_awid    = ID_W'(w_gnt);
  assign o_awaddr  = r_addr;
  assign o_awlen   = r_len;
  assign o_awsize  = r_size;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0000;
  assign o_awprot  = 3'b000;

  assign o_rready  = (r_state == ST_R);
  assign o_bready  = (r_state == ST_B);

  // Write data passes straight through from the granted master, which
  // advances its data on each ready pulse.
  assign w_wlast   = (r_beat == r_len);
  assign o_wvalid  = (r_state == ST_W) && i_creq[w_gnt].valid;
  assign o_wlast   = (r_state == ST_W) && w_wlast;
  assign o_wid     = ID_W'(w_gnt);
  assign o_wdata   = i_creq[w_gnt].data;
  assign o_wstrb   = i_creq[w_gnt].strobe;
  assign w_whs     = o_wvalid && i_wready;

  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) o_cresp[i] = '0;

    case (r_state)
      ST_IDLE: begin
        w_arb_en = 1'b1;
        if (w_win_valid) begin
          w_state_nxt = i_creq[w_win_idx].is_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        if (i_arready) w_state_nxt = ST_R;
      end
      ST_R: begin
        if (i_rvalid) begin
          o_cresp[w_gnt].ready = 1'b1;
          o_cresp[w_gnt].last  = i_rlast;
          o_cresp[w_gnt].data  = i_rdata;
          if (i_rlast) w_state_nxt = ST_IDLE;
        end
      end
      ST_AW: begin
        if (i_awready) w_state_nxt = ST_W;
      end
      ST_W: begin
        // The final beat's acknowledgement is deferred to the B response.
        if (w_whs) begin
          if (w_wlast) w_state_nxt = ST_B;
          else         o_cresp[w_gnt].ready = 1'b1;
        end
      end
      ST_B: begin
        if (i_bvalid) begin
          o_cresp[w_gnt].ready = 1'b1;
          o_cresp[w_gnt].last  = 1'b1;
          w_state_nxt          = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_win_valid) begin
        r_addr <= i_creq[w_win_idx].addr;
        r_size <= i_creq[w_win_idx].size;
        r_len  <= clamp_len(i_creq[w_win_idx].len, MAX_LEN);
      end
      if (w_whs) begin
        r_beat <= w_wlast ? 4'd0 : r_beat + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire
